// File: rtl/mold_seq_ctrl_if.sv
// mold_seq_ctrl_if: header, frame and gap-request signals between the Mold parser and mold_seq_ctrl
// master: parser/requester side (drives header, frame-end and gapReadyIn); slave: mold_seq_ctrl
interface mold_seq_ctrl_if #(
    parameter int SESS_W = 80,
    parameter int SEQ_W  = 64,
    parameter int GAP_W  = 32
);
    logic              hdrValidIn;
    logic [SESS_W-1:0] sessIdIn;
    logic [SEQ_W-1:0]  seqNumIn;
    logic [15:0]       msgCntIn;
    logic              frameEndIn;
    logic              frameGoodIn;
    logic              fwdEnOut;
    logic [15:0]       skipCntOut;
    logic              packetLostOut;
    logic              gapValidOut;
    logic [SEQ_W-1:0]  gapStartOut;
    logic [GAP_W-1:0]  gapCntOut;
    logic              gapReadyIn;
    logic [SEQ_W-1:0]  expSeqOut;
    logic              syncedOut;
    modport master (
        output hdrValidIn, sessIdIn, seqNumIn, msgCntIn, frameEndIn, frameGoodIn, gapReadyIn,
        input  fwdEnOut, skipCntOut, packetLostOut, gapValidOut, gapStartOut, gapCntOut, expSeqOut, syncedOut
    );
    modport slave (
        input  hdrValidIn, sessIdIn, seqNumIn, msgCntIn, frameEndIn, frameGoodIn, gapReadyIn,
        output fwdEnOut, skipCntOut, packetLostOut, gapValidOut, gapStartOut, gapCntOut, expSeqOut, syncedOut
    );
endinterface

// File: rtl/mold_seq_ctrl.sv
// mold_seq_ctrl: MoldUDP64 sequence tracking, payload forward/drop/skip gating and retransmit-gap requests
// clkIn/rstIn: parser clock, async active-high reset; bus: header/frame inputs, forward/gap/status outputs
module mold_seq_ctrl #(
    parameter int SESS_W = 80,
    parameter int SEQ_W  = 64,
    parameter int GAP_W  = 32
) (
    input  logic           clkIn,
    input  logic           rstIn,
    mold_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {UNSYNC, WAIT_HDR, FWD, DROP} stateT;
    localparam logic [GAP_W-1:0] GAP_MAX = '1;
    stateT             state, nextState;
    logic [SESS_W-1:0] sessReg;
    logic [SEQ_W-1:0]  curEnd, curGapStart;
    logic [GAP_W-1:0]  curGapCnt;
    logic              curEos, curFresh, curGap;
    logic              inFrame, endNow, good, baseUnsync, isEos, resync, hdrFwd, gapHit;
    logic [SEQ_W-1:0]  e1, nEff, sn, diff, mergeSum;
    logic [15:0]       hdrSkip;
    logic [GAP_W-1:0]  gapCntSat, mergeCnt;
    always_comb begin
        inFrame    = (state == FWD) || (state == DROP);
        endNow     = inFrame && bus.frameEndIn;
        good       = endNow && bus.frameGoodIn;
        // e1 is expSeq after committing the ending frame; a first frame of a session sets it outright
        e1         = !good ? bus.expSeqOut : curFresh ? curEnd : (curEnd > bus.expSeqOut ? curEnd : bus.expSeqOut);
        // state the new header is judged from once the old frame is committed or abandoned
        baseUnsync = (state == UNSYNC) || (inFrame && (good ? curEos : curFresh));
        isEos      = bus.msgCntIn == 16'hFFFF;
        nEff       = isEos ? '0 : SEQ_W'(bus.msgCntIn);
        sn         = bus.seqNumIn + nEff;
        resync     = baseUnsync || (bus.sessIdIn != sessReg);
        hdrFwd     = (nEff != '0) && (resync || bus.seqNumIn >= e1 || sn > e1);
        gapHit     = !resync && (bus.seqNumIn > e1);
        hdrSkip    = (!resync && bus.seqNumIn < e1) ? 16'(e1 - bus.seqNumIn) : 16'd0;
        diff       = bus.seqNumIn - e1;
        gapCntSat  = (diff > SEQ_W'(GAP_MAX)) ? GAP_MAX : GAP_W'(diff);
        mergeSum   = curGapStart + SEQ_W'(curGapCnt) - bus.gapStartOut;
        mergeCnt   = (mergeSum > SEQ_W'(GAP_MAX)) ? GAP_MAX : GAP_W'(mergeSum);
        nextState  = bus.hdrValidIn ? (hdrFwd ? FWD : DROP) : endNow ? (baseUnsync ? UNSYNC : WAIT_HDR) : state;
    end
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state             <= UNSYNC;
            sessReg           <= '0;
            curEnd            <= '0;
            curGapStart       <= '0;
            curGapCnt         <= '0;
            curEos            <= 1'b0;
            curFresh          <= 1'b0;
            curGap            <= 1'b0;
            bus.fwdEnOut      <= 1'b0;
            bus.skipCntOut    <= '0;
            bus.packetLostOut <= 1'b0;
            bus.gapValidOut   <= 1'b0;
            bus.gapStartOut   <= '0;
            bus.gapCntOut     <= '0;
            bus.expSeqOut     <= '0;
            bus.syncedOut     <= 1'b0;
        end else begin
            state             <= nextState;
            bus.expSeqOut     <= e1;
            bus.fwdEnOut      <= nextState == FWD;
            bus.skipCntOut    <= bus.hdrValidIn ? (hdrFwd ? hdrSkip : 16'd0) : endNow ? 16'd0 : bus.skipCntOut;
            bus.syncedOut     <= (bus.hdrValidIn && !baseUnsync && bus.sessIdIn != sessReg) ? 1'b0 :
                                 good ? !curEos : bus.syncedOut;
            bus.packetLostOut <= good && curGap;
            if (good && curGap) begin
                bus.gapValidOut <= 1'b1;
                if (!bus.gapValidOut || bus.gapReadyIn) begin
                    bus.gapStartOut <= curGapStart;
                    bus.gapCntOut   <= curGapCnt;
                end else begin
                    bus.gapCntOut <= mergeCnt;
                end
            end else if (bus.gapReadyIn) begin
                bus.gapValidOut <= 1'b0;
            end
            if (bus.hdrValidIn) begin
                sessReg     <= bus.sessIdIn;
                curEnd      <= sn;
                curEos      <= isEos;
                curFresh    <= resync;
                curGap      <= gapHit;
                curGapStart <= e1;
                curGapCnt   <= gapCntSat;
            end
        end
    end
endmodule

// File: tb/tb_mold_seq_ctrl.sv
// tb_mold_seq_ctrl: scoreboard bench for mold_seq_ctrl against a frame-level reference model
module tb_mold_seq_ctrl;
    logic clkIn = 1'b0;
    logic rstIn = 1'b0;
    always #5 clkIn = ~clkIn;
    mold_seq_ctrl_if bus ();
    mold_seq_ctrl dut (.clkIn(clkIn), .rstIn(rstIn), .bus(bus.slave));

    typedef struct packed {
        logic        fwd;
        logic [15:0] skip;
        logic        lost;
        logic        gv;
        logic [63:0] gs;
        logic [31:0] gc;
        logic [63:0] exp;
        logic        sync;
    } outT;
    typedef struct packed {
        logic [63:0] s;
        logic [31:0] c;
    } gapT;
    outT stQ[$];
    gapT gapQ[$];
    outT eR, aR;
    gapT gR;
    int  tests = 0;
    int  fails = 0;
    logic ready = 1'b0;

    // reference model: session lock, one in-flight frame record, one gap slot
    logic        mLocked, mSynced, mFwd, mLost, fIn, fFresh, fEos, fGap, gV;
    logic [79:0] mSess;
    logic [63:0] mExp, fEnd, fGS, gS;
    logic [15:0] mSkip;
    logic [31:0] fGC, gC;

    function automatic logic [31:0] sat(input logic [63:0] x);
        return (x > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : x[31:0];
    endfunction

    task automatic modelReset();
        {mLocked, mSynced, mFwd, mLost, fIn, fFresh, fEos, fGap, gV} = '0;
        mSess = '0; mExp = '0; fEnd = '0; fGS = '0; gS = '0; mSkip = '0; fGC = '0; gC = '0;
    endtask

    task automatic modelStep(input logic hdr, input logic [79:0] sess, input logic [63:0] s,
                             input logic [15:0] n, input logic fe, input logic fg, input logic rdy);
        logic [63:0] nn, sn;
        logic        newGap, eos, fwd;
        logic [15:0] skip;
        newGap = 1'b0;
        if (gV && rdy) gapQ.push_back({gS, gC});
        if (fIn && fe) begin
            if (fg) begin
                mExp    = fFresh ? fEnd : ((fEnd > mExp) ? fEnd : mExp);
                mSynced = !fEos;
                mLocked = !fEos;
                newGap  = fGap;
            end
            fIn = 1'b0; mFwd = 1'b0; mSkip = '0;
        end
        mLost = newGap;
        if (newGap) begin
            if (!gV || rdy) begin
                gV = 1'b1; gS = fGS; gC = fGC;
            end else begin
                gC = sat(fGS + {32'd0, fGC} - gS);
            end
        end else if (rdy) begin
            gV = 1'b0;
        end
        if (hdr) begin
            eos  = n == 16'hFFFF;
            nn   = eos ? 64'd0 : {48'd0, n};
            sn   = s + nn;
            skip = '0;
            fGap = 1'b0;
            if (!mLocked || sess != mSess) begin
                if (mLocked) mSynced = 1'b0;
                fFresh = 1'b1; mLocked = 1'b0; fwd = nn != 0;
            end else begin
                fFresh = 1'b0;
                if (nn == 0) begin
                    fwd = 1'b0; fGap = s > mExp;
                end else if (s == mExp) begin
                    fwd = 1'b1;
                end else if (s > mExp) begin
                    fwd = 1'b1; fGap = 1'b1;
                end else if (sn <= mExp) begin
                    fwd = 1'b0;
                end else begin
                    fwd = 1'b1; skip = 16'(mExp - s);
                end
            end
            fGS = mExp; fGC = sat(s - mExp);
            mSess = sess; fEnd = sn; fEos = eos; fIn = 1'b1;
            mFwd = fwd; mSkip = fwd ? skip : 16'd0;
        end
        stQ.push_back({mFwd, mSkip, mLost, gV, gS, gC, mExp, mSynced});
    endtask

    // one clock of stimulus, entered and left 1 time unit after a rising edge
    task automatic cyc(input logic hdr, input logic [79:0] sess, input logic [63:0] s,
                       input logic [15:0] n, input logic fe, input logic fg);
        bus.hdrValidIn  = hdr;
        bus.sessIdIn    = sess;
        bus.seqNumIn    = s;
        bus.msgCntIn    = n;
        bus.frameEndIn  = fe;
        bus.frameGoodIn = fg;
        bus.gapReadyIn  = ready;
        modelStep(hdr, sess, s, n, fe, fg, ready);
        @(posedge clkIn);
        #1;
    endtask

    task automatic hdr(input logic [79:0] sess, input logic [63:0] s, input logic [15:0] n);
        cyc(1'b1, sess, s, n, 1'b0, 1'b0);
    endtask

    task automatic endf(input logic g);
        cyc(1'b0, '0, '0, '0, 1'b1, g);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rstIn = 1'b1;
        #1;
        tests++;
        if ({bus.fwdEnOut, bus.skipCntOut, bus.packetLostOut, bus.gapValidOut, bus.gapStartOut,
             bus.gapCntOut, bus.expSeqOut, bus.syncedOut} !== '0) begin
            fails++;
            $display("FAIL reset: got fwd=%b skip=%0d lost=%b gv=%b exp=%0d sync=%b, expected all zero",
                     bus.fwdEnOut, bus.skipCntOut, bus.packetLostOut, bus.gapValidOut, bus.expSeqOut, bus.syncedOut);
        end
        stQ.delete();
        gapQ.delete();
        modelReset();
        {bus.hdrValidIn, bus.frameEndIn, bus.frameGoodIn, bus.gapReadyIn} = '0;
        repeat (2) @(posedge clkIn);
        #1;
        rstIn = 1'b0;
        stQ.push_back('0);
    endtask

    always @(negedge clkIn) begin
        if (!rstIn && stQ.size() > 0) begin
            eR = stQ.pop_front();
            aR = {bus.fwdEnOut, bus.skipCntOut, bus.packetLostOut, bus.gapValidOut, bus.gapStartOut,
                  bus.gapCntOut, bus.expSeqOut, bus.syncedOut};
            if (!eR.gv) begin
                eR.gs = '0; eR.gc = '0; aR.gs = '0; aR.gc = '0;
            end
            tests++;
            if (aR !== eR) begin
                fails++;
                $display("FAIL outputs @%0t: got fwd=%b skip=%0d lost=%b gv=%b gs=%0d gc=%0d exp=%0d sync=%b, expected fwd=%b skip=%0d lost=%b gv=%b gs=%0d gc=%0d exp=%0d sync=%b",
                         $time, aR.fwd, aR.skip, aR.lost, aR.gv, aR.gs, aR.gc, aR.exp, aR.sync,
                         eR.fwd, eR.skip, eR.lost, eR.gv, eR.gs, eR.gc, eR.exp, eR.sync);
            end
        end
        if (!rstIn && bus.gapValidOut === 1'b1 && bus.gapReadyIn === 1'b1) begin
            tests++;
            if (gapQ.size() == 0) begin
                fails++;
                $display("FAIL gapAccept @%0t: got transfer start=%0d cnt=%0d, expected none",
                         $time, bus.gapStartOut, bus.gapCntOut);
            end else begin
                gR = gapQ.pop_front();
                if (gR.s !== bus.gapStartOut || gR.c !== bus.gapCntOut) begin
                    fails++;
                    $display("FAIL gapAccept @%0t: got start=%0d cnt=%0d, expected start=%0d cnt=%0d",
                             $time, bus.gapStartOut, bus.gapCntOut, gR.s, gR.c);
                end
            end
        end
    end

    logic [79:0] rs;
    logic [63:0] rS;
    logic [15:0] rN;
    logic        pend, pg;
    int          r;

    initial begin
        {bus.hdrValidIn, bus.frameEndIn, bus.frameGoodIn, bus.gapReadyIn} = '0;
        bus.sessIdIn = '0; bus.seqNumIn = '0; bus.msgCntIn = '0;
        modelReset();
        @(posedge clkIn);
        #1;
        doReset();
        hdr(80'd4, 64'd1, 16'd1); idle(); endf(1'b1); idle(); idle();
        hdr(80'd4, 64'd3, 16'd1); idle(); endf(1'b1); idle(); idle(); idle();
        ready = 1'b1; idle(); ready = 1'b0; idle();
        hdr(80'd4, 64'd2, 16'd1); endf(1'b1);
        hdr(80'd4, 64'd3, 16'd3); idle(); endf(1'b1); idle();
        hdr(80'd4, 64'd6, 16'd2); idle(); endf(1'b0); idle();
        hdr(80'd4, 64'd9, 16'd0); endf(1'b1); idle();
        ready = 1'b1; idle(); ready = 1'b0;
        hdr(80'd4, 64'd10, 16'd2); endf(1'b1); idle();
        hdr(80'd4, 64'd14, 16'd1); endf(1'b1); idle(); idle();
        ready = 1'b1; idle(); ready = 1'b0;
        hdr(80'd4, 64'd15, 16'd1);
        cyc(1'b1, 80'd4, 64'd16, 16'd2, 1'b1, 1'b1);
        idle(); endf(1'b1); idle();
        hdr(80'd4, 64'd18 + (64'd1 << 33), 16'd1); endf(1'b1); idle();
        ready = 1'b1; idle(); ready = 1'b0;
        hdr(80'd4, mExp + 64'd1, 16'd1); endf(1'b1);
        hdr(80'd4, mExp + (64'd1 << 40), 16'd1); endf(1'b1); idle();
        ready = 1'b1; idle(); ready = 1'b0;
        hdr(80'd5, 64'd100, 16'd1); idle(); endf(1'b1); idle();
        hdr(80'd6, 64'd7, 16'd1); endf(1'b0); idle();
        hdr(80'd6, 64'd7, 16'd1); endf(1'b1); idle();
        hdr(80'd6, 64'd8, 16'd2); idle(); hdr(80'd6, 64'd10, 16'd1); endf(1'b1); idle();
        hdr(80'd6, mExp, 16'hFFFF); endf(1'b1); idle();
        endf(1'b1);
        hdr(80'd6, 64'd50, 16'd1); endf(1'b1); idle();
        ready = 1'b1; idle(); ready = 1'b0;
        hdr(80'd7, 64'd1, 16'd3);
        doReset();
        rs = 80'd4; pend = 1'b0; pg = 1'b0;
        for (int i = 0; i < 600; i++) begin
            ready = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 24) == 0) rs = 80'($urandom_range(4, 6));
            rS = ((mExp > 64'd4) ? mExp - 64'd4 : 64'd0) + 64'($urandom_range(0, 8));
            rN = ($urandom_range(0, 29) == 0) ? 16'hFFFF : 16'($urandom_range(0, 4));
            cyc(1'b1, rs, rS, rN, pend, pg);
            repeat ($urandom_range(0, 3)) begin
                ready = $urandom_range(0, 2) == 0;
                idle();
            end
            r = $urandom_range(0, 7);
            ready = $urandom_range(0, 2) == 0;
            if (r == 0) begin
                pend = 1'b0;
            end else if (r == 1) begin
                pend = 1'b1;
                pg   = $urandom_range(0, 4) != 0;
            end else begin
                pend = 1'b0;
                endf($urandom_range(0, 4) != 0);
                if (r == 2) endf(1'b1);
            end
        end
        ready = 1'b1;
        repeat (4) idle();
        @(negedge clkIn);
        #1;
        tests++;
        if (stQ.size() != 0 || gapQ.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d state and %0d gap entries outstanding, expected 0 and 0", stQ.size(), gapQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
